// File: rtl/fault_pattern_gen_if.sv
// Controller/fault-model side signals of fault_pattern_gen.
// slave = generator view, master = controller/fault-model view.
interface fault_pattern_gen_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 9
);
    logic             start;
    logic             abort;
    logic             fault_detected;
    logic [WIDTH-1:0] test_vector;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] fail_count;
    logic [WIDTH-1:0] first_fail_vec;
    logic             first_fail_vld;

    modport slave (
        input  start, abort, fault_detected,
        output test_vector, busy, done, fail_count, first_fail_vec, first_fail_vld
    );

    modport master (
        output start, abort, fault_detected,
        input  test_vector, busy, done, fail_count, first_fail_vec, first_fail_vld
    );
endinterface

// File: rtl/fault_pattern_gen.sv
// Applies a sequence of test vectors to a fault model and tallies detected faults.
// Build option FAULT_PATTERN_LFSR_EN: Galois LFSR sequence from SEED instead of an up-counter from 0.
module fault_pattern_gen #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      NUM_VECTORS = 256,
    parameter int unsigned      RESP_LAT    = 1,
    parameter int unsigned      CNT_W       = 9,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             reset,
    fault_pattern_gen_if.slave bus
);

    localparam int unsigned IDX_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int unsigned HOLD_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

`ifdef FAULT_PATTERN_LFSR_EN
    localparam bit LFSR_EN = 1'b1;
`else
    localparam bit LFSR_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0]  FIRST_VEC = LFSR_EN ? SEED : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(RESP_LAT - 1);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    vec_q, vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [WIDTH-1:0]    ffv_q, ffv_d;
    logic                ffvld_q, ffvld_d;

    // Sequence step: Galois LFSR right-shift, or binary increment wrapping at 2**WIDTH.
    function automatic logic [WIDTH-1:0] next_vec(input logic [WIDTH-1:0] v);
        if (LFSR_EN)
            return (v >> 1) ^ (v[0] ? TAPS : '0);
        else
            return v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= '0;
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        ffvld_d = ffvld_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.abort && bus.start) begin
                    fail_d  = '0;
                    ffv_d   = '0;
                    ffvld_d = 1'b0;
                    vec_d   = FIRST_VEC;
                    hold_d  = '0;
                    idx_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (bus.abort)
                    state_d = IDLE;
                else if (hold_q == LAST_HOLD)
                    state_d = SAMPLE;
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (bus.fault_detected) begin
                        if (fail_q != '1)
                            fail_d = fail_q + CNT_W'(1);
                        if (!ffvld_q) begin
                            ffv_d   = vec_q;
                            ffvld_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        vec_d   = next_vec(vec_q);
                        hold_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status flags are registered decodes of the state being entered.
        busy_d = (state_d == HOLD) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    assign bus.test_vector    = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.fail_count     = fail_q;
    assign bus.first_fail_vec = ffv_q;
    assign bus.first_fail_vld = ffvld_q;

endmodule
